// File: rtl/ctrl_time_seq_pkg.sv
// ctrl_time_seq_pkg: shared widths and state encoding for the time-step sequencer
package ctrl_time_seq_pkg;
  localparam int CNT_W_DEF  = 12;
  localparam int DIV_W_DEF  = 8;
  localparam int STEP_W_DEF = 16;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/ctrl_time_prescaler.sv
// ctrl_time_prescaler: divide-by-(div+1) counter with a registered tick in the last clock of each count
module ctrl_time_prescaler
  import ctrl_time_seq_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] q, nq;
  // en means the coming cycle counts; clr starts that cycle from a fresh count
  always_comb nq = (clr || tick) ? '0 : q + DIV_W'(1);
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      q    <= '0;
      tick <= 1'b0;
    end else begin
      q    <= nq;
      tick <= (nq == div);
    end
  end
endmodule

// File: rtl/ctrl_time_seq.sv
// ctrl_time_seq: time-step sequencer emitting per-step start pulses, a position counter and completion
module ctrl_time_seq
  import ctrl_time_seq_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DIV_W  = DIV_W_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              abort,
  input  logic [CNT_W-1:0]  period,
  input  logic [DIV_W-1:0]  div,
  input  logic [STEP_W-1:0] n_steps,
  output logic              sta,
  output logic [CNT_W-1:0]  counter,
  output logic              tick,
  output logic              step_end,
  output logic              busy,
  output logic              done
);
  state_t              state;
  logic [CNT_W-1:0]    period_q;
  logic [DIV_W-1:0]    div_q, div_eff;
  logic [STEP_W-1:0]   n_steps_q, step_cnt, step_nx;
  logic                wrap, fin, run_nx;
  // period 0 wraps at all-ones naturally through the modular subtraction
  always_comb begin
    wrap    = tick && (counter == period_q - CNT_W'(1));
    step_nx = step_cnt + STEP_W'(1);
    fin     = wrap && (n_steps_q != '0) && (step_nx == n_steps_q);
    run_nx  = (state == S_IDLE) ? (go && !abort) :
              (state == S_RUN)  ? (!abort && !fin) : 1'b0;
    div_eff = (state == S_IDLE) ? div : div_q;
  end
  ctrl_time_prescaler #(.DIV_W(DIV_W)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == S_IDLE),
    .en   (run_nx),
    .div  (div_eff),
    .tick (tick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      period_q  <= '0;
      div_q     <= '0;
      n_steps_q <= '0;
      step_cnt  <= '0;
      counter   <= '0;
      sta       <= 1'b0;
      step_end  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      sta      <= 1'b0;
      step_end <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          counter <= '0;
          if (go && !abort) begin
            state     <= S_RUN;
            period_q  <= period;
            div_q     <= div;
            n_steps_q <= n_steps;
            step_cnt  <= '0;
            sta       <= 1'b1;
            busy      <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        S_RUN: begin
          if (abort) begin
            state    <= S_IDLE;
            counter  <= '0;
            step_cnt <= '0;
            busy     <= 1'b0;
          end else if (fin) begin
            state    <= S_DONE;
            counter  <= '0;
            step_cnt <= step_nx;
            busy     <= 1'b0;
            done     <= 1'b1;
            step_end <= 1'b1;
          end else if (wrap) begin
            counter  <= '0;
            step_cnt <= step_nx;
            sta      <= 1'b1;
            step_end <= 1'b1;
          end else if (tick) begin
            counter <= counter + CNT_W'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          counter <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/ctrl_time_seq.md
CTRL_TIME_SEQ -- requirements
Module: ctrl_time_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 12: width of time-step counter output.
REQ-002 SHALL have parameter DIV_W, default 8: width of clock prescaler divisor.
REQ-003 SHALL have parameter STEP_W, default 16: width of time-step count.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port go  input  1  start request, sampled in IDLE only.
REQ-007 SHALL have port abort  input  1  stop request, honoured in any state.
REQ-008 SHALL have port period  input  CNT_W  counts per time step; 0 means 2^CNT_W.
REQ-009 SHALL have port div  input  DIV_W  clocks per count minus one.
REQ-010 SHALL have port n_steps  input  STEP_W  time steps to run; 0 means run until abort.
REQ-011 SHALL have port sta  output  1  one-cycle pulse at start of every time step (feeds downstream schedule-index restart).
REQ-012 SHALL have port counter  output  CNT_W  position within current time step.
REQ-013 SHALL have port tick  output  1  high in the last clock of each count.
REQ-014 SHALL have port step_end  output  1  one-cycle pulse after each completed time step.
REQ-015 SHALL have port busy  output  1  high while in RUN.
REQ-016 SHALL have port done  output  1  one-cycle pulse on normal completion.

Function
REQ-017 SHALL implement states IDLE, RUN, DONE; all outputs registered.
REQ-018 SHALL, on go=1 in IDLE at cycle T, latch period, div, n_steps and enter RUN at T+1 with sta=1, counter=0, prescaler=0, step count=0.
REQ-019 SHALL ignore go outside IDLE and ignore input changes after latching.
REQ-020 SHALL in RUN advance prescaler each cycle; tick=1 when prescaler==div, then prescaler returns to 0 (div=0: tick every RUN cycle).
REQ-021 SHALL increment counter on the edge ending a tick cycle; if counter==period-1 (or 2^CNT_W-1 for period=0) counter wraps to 0.
REQ-022 SHALL on a wrap increment step count; if it then equals n_steps (n_steps!=0) enter DONE, else stay in RUN with sta=1 and step_end=1 for the following cycle.
REQ-023 SHALL in DONE drive done=1, step_end=1, sta=0, busy=0, counter=0 for one cycle, then enter IDLE.
REQ-024 SHALL wrap step count modulo 2^STEP_W silently when n_steps=0.
REQ-025 SHALL on abort=1 enter IDLE next cycle with all outputs 0 and no done/step_end pulse; abort beats go in the same cycle.
REQ-026 SHALL keep sta low except in the first cycle of every time step.

Reset
REQ-027 SHALL on rst=1 enter IDLE next edge; sta, counter, tick, step_end, busy, done all 0; prescaler and step count 0.
REQ-028 SHALL give rst priority over go and abort, including mid-RUN.

Structure
REQ-029 SHALL take CNT_W, DIV_W, STEP_W defaults and state encodings from the shared global parameter file.
REQ-030 SHALL place the divide-by-(div+1) counter in one sub-module, ctrl_time_prescaler (inputs clk, rst, clr, en, div; output tick).

Verification
REQ-031 period=4, div=1, n_steps=2, go at cycle 0 -> sta at 1 and 9; counter 0,0,1,1,2,2,3,3 over 1-8; tick at 2,4,6,8,...,16; done and step_end at 17; IDLE at 18.
REQ-032 period=3, div=0, n_steps=0, run 10 cycles then abort -> counter 0,1,2,0,1,2,...; sta every 3rd cycle; no done; all outputs 0 cycle after abort.
REQ-033 period=0, div=0, n_steps=1 -> counter reaches 4095, wraps; done at 4097 cycles after go.
REQ-034 go re-pulsed mid-RUN and period changed -> no effect; sequence identical to REQ-031.
REQ-035 rst at cycle 5 of REQ-031 run -> cycle 6 all outputs 0, IDLE; go at cycle 7 restarts cleanly with sta at cycle 8.
REQ-036 go and abort together in IDLE -> stays IDLE, sta never asserted.
